// File: rtl/show_sequencer.sv
// Latches three 7-segment patterns on a debounced-free push of `show` and plays them A, B, C on one shared digit.
// Optional SHOW_SEQUENCER_GAP_EN inserts a one-tick blank between A->B and B->C.
module show_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       show,
  input  logic [6:0] seg_a,
  input  logic [6:0] seg_b,
  input  logic [6:0] seg_c,
  output logic [6:0] num_led,
  output logic       busy,
  output logic [1:0] phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

`ifdef SHOW_SEQUENCER_GAP_EN
  typedef enum logic [2:0] {IDLE, SHOW_A, SHOW_B, SHOW_C, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SHOW_A, SHOW_B, SHOW_C} state_t;
`endif

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [6:0]    snap_a_q, snap_a_d, snap_b_q, snap_b_d, snap_c_q, snap_c_d;
  logic [6:0]    num_led_q, num_led_d;
  logic          busy_q, busy_d;
  logic [1:0]    phase_q, phase_d;
  logic          start, tick;

  // sync3_q is only the previous synchronized level, used for edge detection
  assign start = sync2_q & ~sync3_q;
  assign tick  = (state_q != IDLE) && (presc_q == PRE_LAST);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    snap_c_d = snap_c_q;
    if (state_q != IDLE) presc_d = tick ? '0 : presc_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHOW_A;
          snap_a_d = seg_a;
          snap_b_d = seg_b;
          snap_c_d = seg_c;
        end
      end
      SHOW_A, SHOW_B, SHOW_C: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            case (state_q)
`ifdef SHOW_SEQUENCER_GAP_EN
              SHOW_A:  state_d = GAP;
              SHOW_B:  state_d = GAP;
`else
              SHOW_A:  state_d = SHOW_B;
              SHOW_B:  state_d = SHOW_C;
`endif
              default: state_d = IDLE;
            endcase
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
`ifdef SHOW_SEQUENCER_GAP_EN
      // phase still names the digit just shown, which tells us where to resume
      GAP:     if (tick) state_d = (phase_q == 2'd1) ? SHOW_B : SHOW_C;
`endif
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      hold_d  = '0;
    end

    num_led_d = 7'b0000000;
    phase_d   = 2'd0;
    busy_d    = (state_d != IDLE);
    case (state_d)
      SHOW_A: begin num_led_d = snap_a_d; phase_d = 2'd1; end
      SHOW_B: begin num_led_d = snap_b_d; phase_d = 2'd2; end
      SHOW_C: begin num_led_d = snap_c_d; phase_d = 2'd3; end
`ifdef SHOW_SEQUENCER_GAP_EN
      GAP:    phase_d = phase_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      presc_q   <= '0;
      hold_q    <= '0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      snap_c_q  <= '0;
      num_led_q <= '0;
      busy_q    <= 1'b0;
      phase_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= show;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      snap_c_q  <= snap_c_d;
      num_led_q <= num_led_d;
      busy_q    <= busy_d;
      phase_q   <= phase_d;
    end
  end

  assign num_led = num_led_q;
  assign busy    = busy_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_show_sequencer.sv
// Directed bench for show_sequencer with TICK_DIV=4, HOLD_TICKS=2 (8 cycles per digit).
// Expectations follow SHOW_SEQUENCER_GAP_EN the same way the design build does.
module tb_show_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       show;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [6:0] num_led;
  logic       busy;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SHOW_SEQUENCER_GAP_EN
  localparam int BUSY_LEN  = 32;
  localparam int RETRIG_K  = 16;
  localparam int RST_K     = 30;
`else
  localparam int BUSY_LEN  = 24;
  localparam int RETRIG_K  = 12;
  localparam int RST_K     = 20;
`endif

  show_sequencer #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .reset(reset), .show(show),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c),
    .num_led(num_led), .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // k counts rising edges since show went high; edge 3 is the first A cycle.
  // Returns 0 idle, 1 A, 2 B, 3 C, 4 gap after A, 5 gap after B.
  function automatic int exp_state(input int k);
`ifdef SHOW_SEQUENCER_GAP_EN
    if (k < 3)  return 0;
    if (k <= 10) return 1;
    if (k <= 14) return 4;
    if (k <= 22) return 2;
    if (k <= 26) return 5;
    if (k <= 34) return 3;
    return 0;
`else
    if (k < 3)  return 0;
    if (k <= 10) return 1;
    if (k <= 18) return 2;
    if (k <= 26) return 3;
    return 0;
`endif
  endfunction

  task automatic run_seq(input string name, input int show_len, input int rise_k,
                         input int segb_k, input int ncyc);
    logic [6:0] ea, eb, ec, el;
    int st, ep, busy_cnt;
    ea = seg_a; eb = seg_b; ec = seg_c;
    busy_cnt = 0;
    show = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      st = exp_state(k);
      case (st)
        1: begin el = ea;   ep = 1; end
        2: begin el = eb;   ep = 2; end
        3: begin el = ec;   ep = 3; end
        4: begin el = 7'h0; ep = 1; end
        5: begin el = 7'h0; ep = 2; end
        default: begin el = 7'h0; ep = 0; end
      endcase
      check($sformatf("%s_led_k%0d", name, k), {25'd0, num_led}, {25'd0, el});
      check($sformatf("%s_phase_k%0d", name, k), {30'd0, phase}, ep);
      check($sformatf("%s_busy_k%0d", name, k), {31'd0, busy}, (st != 0) ? 1 : 0);
      if (busy) busy_cnt++;
      if (k == show_len) show = 1'b0;
      if (k == rise_k)   show = 1'b1;
      if (k == segb_k)   seg_b = 7'h7F;
    end
    check({name, "_busy_len"}, busy_cnt, BUSY_LEN);
    show = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    show  = 1'b0;
    seg_a = 7'h30; seg_b = 7'h6D; seg_c = 7'h79;
    #3;
    check("rst_led",   {25'd0, num_led}, 0);
    check("rst_busy",  {31'd0, busy},    0);
    check("rst_phase", {30'd0, phase},   0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run_seq("basic", 20, 0, 0, 40);

    seg_b = 7'h6D;
    run_seq("snap", 20, 0, 4, 40);

    seg_b = 7'h6D;
    run_seq("retrig", 3, RETRIG_K, 0, 44);

    run_seq("held", 100, 0, 0, 110);

    // Abort in C, with show already released
    seg_a = 7'h30; seg_b = 7'h6D; seg_c = 7'h79;
    show = 1'b1;
    for (int k = 1; k <= RST_K; k++) begin
      @(posedge clk); #1;
      if (k == 3) show = 1'b0;
    end
    check("mid_phase_before", {30'd0, phase}, 3);
    reset = 1'b1;
    #1;
    check("mid_led",   {25'd0, num_led}, 0);
    check("mid_busy",  {31'd0, busy},    0);
    check("mid_phase", {30'd0, phase},   0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_k%0d", k), {22'd0, num_led, busy, phase}, 0);
    end

    seg_a = 7'h06; seg_b = 7'h5B; seg_c = 7'h4F;
    run_seq("after_rst", 20, 0, 0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
